// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix-product stream engine.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Result width the engine is normally built with, and its signed limits.
  // These are what a consumer of the default build should expect.
  localparam int DEF_OUT_DATA_WIDTH = 20;
  localparam int DEF_SAT_MAX        = (1 << (DEF_OUT_DATA_WIDTH - 1)) - 1;
  localparam int DEF_SAT_MIN        = -(1 << (DEF_OUT_DATA_WIDTH - 1));

  // Accumulator wide enough for N full-width signed products, N < 2**dim_w.
  function automatic int acc_width(input int data_w, input int dim_w);
    return 2 * data_w + dim_w;
  endfunction

endpackage

// File: rtl/mm_stream_engine_sat_convert.sv
// Combinational wide-to-narrow signed converter: wraps or saturates and flags
// any value that does not fit in OUT_W bits.
module mm_sat_convert #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 20
) (
  input  logic signed [IN_W-1:0]  in_val,
  input  logic                    sat_mode,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    ovf
);

  // One guard bit beyond the wider side keeps the range check uniform whether
  // the input is narrower or wider than the output.
  localparam int EXT_W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;

  logic signed [EXT_W-1:0] ext;
  logic [EXT_W-OUT_W:0]    top;
  logic                    fits;

  assign ext  = {{(EXT_W - IN_W){in_val[IN_W-1]}}, in_val};
  assign top  = ext[EXT_W-1:OUT_W-1];
  assign fits = (&top) | (~|top);

  // Pick truncated value, or the signed limit when saturating an overflow.
  always_comb begin
    ovf     = ~fits;
    out_val = ext[OUT_W-1:0];
    if (!fits && sat_mode) begin
      out_val = ext[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                             : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mm_stream_engine.sv
// Matrix-product stream engine: holds A and B (NxN, signed), computes
// C = A(MxK) * B(KxP) with one MAC per cycle and streams C row-major.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | operands writable, waiting for start
//   MAC   | accumulating A[row][k] * B[k][col], one k per cycle
//   EMIT  | presenting C[row][col]; held until out_ready
//   DONE  | one-cycle done pulse, then back to IDLE
module mm_stream_engine
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int N              = 4,
  parameter int OUT_DATA_WIDTH = 20,
  parameter int IDX_W          = $clog2(N),
  parameter int DIM_W          = $clog2(N + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_enable,
  input  logic                      is_first_mat,
  input  logic [IDX_W-1:0]          i,
  input  logic [IDX_W-1:0]          j,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [DIM_W-1:0]          dim_m,
  input  logic [DIM_W-1:0]          dim_k,
  input  logic [DIM_W-1:0]          dim_p,
  input  logic                      sat_mode,
  input  logic                      start,
  output logic                      busy,
  output logic                      cfg_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_row,
  output logic [IDX_W-1:0]          out_col,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      ovf,
  output logic                      done
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, DIM_W);
  localparam int PROD_W = 2 * DATA_WIDTH;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] a_q [N][N];
  logic signed [DATA_WIDTH-1:0] a_d [N][N];
  logic signed [DATA_WIDTH-1:0] b_q [N][N];
  logic signed [DATA_WIDTH-1:0] b_d [N][N];

  logic [IDX_W-1:0] row_q, row_d, col_q, col_d, k_q, k_d;
  logic [DIM_W-1:0] dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_p_q, dim_p_d;
  logic             sat_q, sat_d, ovf_q, ovf_d, cfg_err_q, cfg_err_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic signed [PROD_W-1:0]         prod;
  logic signed [OUT_DATA_WIDTH-1:0] conv_data;
  logic                             conv_ovf;
  logic                             dims_ok, wr_ok;
  logic                             last_k, last_col, last_row;

  assign dims_ok = (dim_m != '0) && (32'(dim_m) <= N) &&
                   (dim_k != '0) && (32'(dim_k) <= N) &&
                   (dim_p != '0) && (32'(dim_p) <= N);

  assign wr_ok = wr_enable && (state_q == IDLE) && (32'(i) < N) && (32'(j) < N);

  assign last_k   = (DIM_W'(k_q)   == dim_k_q - DIM_W'(1));
  assign last_col = (DIM_W'(col_q) == dim_p_q - DIM_W'(1));
  assign last_row = (DIM_W'(row_q) == dim_m_q - DIM_W'(1));

  assign prod = a_q[row_q][k_q] * b_q[k_q][col_q];

  mm_sat_convert #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_DATA_WIDTH)
  ) u_conv (
    .in_val   (acc_q),
    .sat_mode (sat_q),
    .out_val  (conv_data),
    .ovf      (conv_ovf)
  );

  // Operand writes, accepted only while idle so a running job sees frozen data.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (wr_ok) begin
      if (is_first_mat) a_d[i][j] = in_data;
      else              b_d[i][j] = in_data;
    end
  end

  // Next-state, counters and accumulator.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    dim_m_d   = dim_m_q;
    dim_k_d   = dim_k_q;
    dim_p_d   = dim_p_q;
    sat_d     = sat_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_ok) begin
            dim_m_d = dim_m;
            dim_k_d = dim_k;
            dim_p_d = dim_p;
            sat_d   = sat_mode;
            ovf_d   = 1'b0;
            acc_d   = '0;
            row_d   = '0;
            col_d   = '0;
            k_d     = '0;
            state_d = MAC;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (last_k) state_d = EMIT;
        else        k_d     = k_q + IDX_W'(1);
      end
      EMIT: begin
        if (conv_ovf) ovf_d = 1'b1;
        if (out_ready) begin
          acc_d = '0;
          k_d   = '0;
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = DONE;
            end else begin
              row_d   = row_q + IDX_W'(1);
              state_d = MAC;
            end
          end else begin
            col_d   = col_q + IDX_W'(1);
            state_d = MAC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job and clears operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '{default: '0};
      b_q       <= '{default: '0};
      row_q     <= '0;
      col_q     <= '0;
      k_q       <= '0;
      dim_m_q   <= '0;
      dim_k_q   <= '0;
      dim_p_q   <= '0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      dim_m_q   <= dim_m_d;
      dim_k_q   <= dim_k_d;
      dim_p_q   <= dim_p_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == EMIT);
  assign out_row   = out_valid ? row_q : '0;
  assign out_col   = out_valid ? col_q : '0;
  assign out_data  = out_valid ? conv_data : '0;
  assign ovf       = ovf_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: doc/mm_stream_engine.md
Name: mm_stream_engine

Overview:
- Parametrised successor to the team's single-entry matrix-product helper.
- Holds two signed NxN operand matrices loaded by indexed writes.
- On start, computes the full product C = A(MxK) * B(KxP) with one MAC per cycle.
- Streams each C element in row-major order over a valid/ready output port, with a selectable wrap or saturate mode.
- Sits between the host loader and the result buffer in the matrix-compute path.

Parameters:
- DATA_WIDTH, 8, signed operand element width.
- N, 4, maximum matrix dimension; storage is NxN per operand.
- OUT_DATA_WIDTH, 20, signed result width.
- IDX_W, $clog2(N), width of row/column index ports.
- DIM_W, $clog2(N+1), width of dimension ports.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wr_enable  in  1  write in_data to the selected operand at [i][j].
- is_first_mat  in  1  1 selects A, 0 selects B (only sampled with wr_enable).
- i  in  IDX_W  write row.
- j  in  IDX_W  write column.
- in_data  in  DATA_WIDTH  signed write data.
- dim_m  in  DIM_W  rows of A, sampled at start.
- dim_k  in  DIM_W  inner dimension, sampled at start.
- dim_p  in  DIM_W  columns of B, sampled at start.
- sat_mode  in  1  1 saturates, 0 wraps; sampled at start.
- start  in  1  single-cycle request to begin a product.
- busy  out  1  high outside IDLE.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- out_valid  out  1  result element available.
- out_ready  in  1  consumer accepts the element.
- out_row  out  IDX_W  row of the current element.
- out_col  out  IDX_W  column of the current element.
- out_data  out  OUT_DATA_WIDTH  signed result element.
- ovf  out  1  sticky; set if any element saturated or wrapped in the current job.
- done  out  1  one-cycle pulse after the last element handshake.

Behaviour:
- Reset: all A/B entries are 0, FSM is IDLE, and every output is 0. Reset mid-job aborts the job with no done pulse.
- States:
  - IDLE: start with dims valid -> MAC. Latch dims and sat_mode, clear ovf, set acc=0, row=col=k=0.
  - IDLE: start with any dim equal to 0 or greater than N -> pulse cfg_err and stay IDLE.
  - MAC: each cycle, acc += A[row][k] * B[k][col] (full-width signed product, accumulator with 2*DATA_WIDTH+DIM_W bits). When k == dim_k-1, go to EMIT.
  - EMIT: out_valid=1 and out_data = final acc converted to OUT_DATA_WIDTH.
    - Conversion in saturate mode: clamp to [-2^(OUT_DATA_WIDTH-1), 2^(OUT_DATA_WIDTH-1)-1].
    - Conversion in wrap mode: truncate to the low bits.
    - Set ovf if the value did not fit.
  - EMIT handshake (out_valid && out_ready): advance col, wrapping to 0 and incrementing row at dim_p-1. Clear acc and k, go to MAC. After element (dim_m-1, dim_p-1), go to DONE.
  - DONE: pulse done for one cycle, then IDLE. ovf holds until the next accepted start.
- Output hold: out_row, out_col and out_data are stable while out_valid && !out_ready. out_valid never drops without a handshake.
- Latency: start accepted at cycle T -> first out_valid at T+dim_k+1. Each following element arrives dim_k+1 cycles after the previous handshake. done arrives one cycle after the final handshake.
- wr_enable while busy: ignored, so operands are frozen during a job. In IDLE, write takes effect at the clock edge.
- start while busy: ignored, with no cfg_err.
- wr_enable and start in the same IDLE cycle: the write lands and the job starts. The job reads the post-write contents because MAC begins the next cycle.
- Indices i/j at or above N on write: the write is dropped.

Decomposition:
- Shared package mm_pkg:
  - State enum {IDLE, MAC, EMIT, DONE}.
  - Saturation limit constants derived from OUT_DATA_WIDTH.
  - Accumulator width function.
- One natural sub-module: mm_sat_convert, a combinational wide-to-narrow signed converter with sat_mode input and an overflow flag. Everything else is the top-level FSM, storage and counters.

Test Plan:
- Identity: A=I4, B[r][c]=r*4+c, dims 4/4/4, out_ready=1 -> 16 elements row-major equal to B, first out_valid at T+5, done once, ovf=0.
- Rectangular: dims m=2, k=3, p=1, A=[[1,2,3],[4,5,6]], B=[[1],[-1],[2]] -> outputs (0,0)=5 and (1,0)=11, then done.
- Saturation: OUT_DATA_WIDTH=16, all A=B=-128, dims 4/4/4.
  - sat_mode=1 -> each element 32767, ovf=1.
  - sat_mode=0 -> each element 0 (65536 mod 2^16), ovf=1.
- Backpressure: out_ready low for 3 cycles on element (0,1) -> out_valid, out_row=0, out_col=1 and out_data held stable. The next MAC does not start until the handshake.
- Config/guard: start with dim_k=0 -> cfg_err pulse, busy stays 0. wr_enable during busy changes no result.
- Reset mid-job: assert reset during MAC of element (1,2) -> all outputs 0, no done pulse, A/B read back as 0 after a new job with dims 1/1/1 (result 0).
